// File: rtl/reg16_readback_checker_if.sv
// Bus bundle for the register read-back checker: write strobe, data in/out of the
// monitored register, and the checker's status/result outputs.
interface reg16_readback_checker_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             Write;
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] O;
    logic             Busy;
    logic             Pass;
    logic             Fail;
    logic             Overrun;
    logic [3:0]       Latency;
    logic [WIDTH-1:0] LastExp;
    logic [WIDTH-1:0] LastGot;
    logic [CNT_W-1:0] ErrCount;

    modport master (
        output Write, I, O,
        input  Busy, Pass, Fail, Overrun, Latency, LastExp, LastGot, ErrCount
    );

    modport slave (
        input  Write, I, O,
        output Busy, Pass, Fail, Overrun, Latency, LastExp, LastGot, ErrCount
    );
endinterface

// File: rtl/reg16_readback_checker.sv
// Read-back checker: captures the value written to a register and confirms the
// register output shows it within MAX_LAT edges, reporting pass/fail/overrun.
module reg16_readback_checker #(
    parameter int WIDTH   = 16,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 8
) (
    input logic                     CLK,
    input logic                     RESET_N,
    reg16_readback_checker_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] exp_q,      exp_d;
    logic [3:0]       timer_q,    timer_d;
    logic             pass_q,     pass_d;
    logic             fail_q,     fail_d;
    logic             ovr_q,      ovr_d;
    logic [3:0]       lat_q,      lat_d;
    logic [WIDTH-1:0] last_exp_q, last_exp_d;
    logic [WIDTH-1:0] last_got_q, last_got_d;
    logic [CNT_W-1:0] err_q,      err_d;
    logic             err_inc;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        timer_d    = timer_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        ovr_d      = 1'b0;
        lat_d      = lat_q;
        last_exp_d = last_exp_q;
        last_got_d = last_got_q;
        err_inc    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Write) begin
                    exp_d   = bus.I;
                    timer_d = 4'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A new write abandons the pending check before any compare result counts.
                if (bus.Write) begin
                    ovr_d   = 1'b1;
                    err_inc = 1'b1;
                    exp_d   = bus.I;
                    timer_d = 4'd1;
                end else if (bus.O == exp_q) begin
                    pass_d  = 1'b1;
                    lat_d   = timer_q;
                    state_d = S_IDLE;
                end else if (timer_q == 4'(MAX_LAT)) begin
                    fail_d     = 1'b1;
                    last_exp_d = exp_q;
                    last_got_d = bus.O;
                    err_inc    = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d = (err_inc && (err_q != '1)) ? err_q + 1'b1 : err_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            exp_q      <= '0;
            timer_q    <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            ovr_q      <= 1'b0;
            lat_q      <= '0;
            last_exp_q <= '0;
            last_got_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            timer_q    <= timer_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ovr_q      <= ovr_d;
            lat_q      <= lat_d;
            last_exp_q <= last_exp_d;
            last_got_q <= last_got_d;
            err_q      <= err_d;
        end
    end

    assign bus.Busy     = (state_q == S_WAIT);
    assign bus.Pass     = pass_q;
    assign bus.Fail     = fail_q;
    assign bus.Overrun  = ovr_q;
    assign bus.Latency  = lat_q;
    assign bus.LastExp  = last_exp_q;
    assign bus.LastGot  = last_got_q;
    assign bus.ErrCount = err_q;

endmodule

// File: tb/tb_reg16_readback_checker.sv
// Directed bench for reg16_readback_checker: stimulus pushes expected pulse events into
// a queue; a negedge monitor pops and compares whenever Pass/Fail/Overrun appears.
module tb_reg16_readback_checker;

    localparam int WIDTH   = 16;
    localparam int MAX_LAT = 4;
    localparam int CNT_W   = 8;

    typedef enum int { EV_PASS = 0, EV_FAIL = 1, EV_OVR = 2 } ev_kind_e;

    typedef struct {
        ev_kind_e         kind;
        logic [3:0]       lat;
        logic [WIDTH-1:0] lexp;
        logic [WIDTH-1:0] lgot;
        logic [CNT_W-1:0] err;
    } ev_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    ev_t  sb_q[$];
    ev_t  mon_e;
    int   mon_n;
    int   mon_kind;

    reg16_readback_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    reg16_readback_checker #(
        .WIDTH  (WIDTH),
        .MAX_LAT(MAX_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] o);
        bus.Write = w;
        bus.I     = i;
        bus.O     = o;
    endtask

    task automatic push(input ev_kind_e k, input logic [3:0] lat, input logic [WIDTH-1:0] le,
                        input logic [WIDTH-1:0] lg, input logic [CNT_W-1:0] err);
        ev_t e;
        e.kind = k;
        e.lat  = lat;
        e.lexp = le;
        e.lgot = lg;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_n = int'(bus.Pass) + int'(bus.Fail) + int'(bus.Overrun);
            if (mon_n != 0) begin
                check("pulse_exclusive", 32'(mon_n), 32'd1);
                mon_kind = bus.Pass ? 0 : (bus.Fail ? 1 : 2);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got kind=%0d expected none at %0t", mon_kind, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("event_kind", 32'(mon_kind), 32'(int'(mon_e.kind)));
                    check("err_count", 32'(bus.ErrCount), 32'(mon_e.err));
                    if (mon_e.kind == EV_PASS)
                        check("latency", 32'(bus.Latency), 32'(mon_e.lat));
                    if (mon_e.kind == EV_FAIL) begin
                        check("last_exp", 32'(bus.LastExp), 32'(mon_e.lexp));
                        check("last_got", 32'(bus.LastGot), 32'(mon_e.lgot));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        #12;
        check("rst_busy",    32'(bus.Busy),     32'd0);
        check("rst_pass",    32'(bus.Pass),     32'd0);
        check("rst_fail",    32'(bus.Fail),     32'd0);
        check("rst_ovr",     32'(bus.Overrun),  32'd0);
        check("rst_latency", 32'(bus.Latency),  32'd0);
        check("rst_lastexp", 32'(bus.LastExp),  32'd0);
        check("rst_lastgot", 32'(bus.LastGot),  32'd0);
        check("rst_err",     32'(bus.ErrCount), 32'd0);
        step();
        rst_n = 1'b1;

        // 1: match one edge after capture
        drive(1'b1, 16'h1234, 16'h0000);
        step();
        check("t1_busy", 32'(bus.Busy), 32'd1);
        drive(1'b0, 16'h0000, 16'h1234);
        push(EV_PASS, 4'd1, '0, '0, 8'd0);
        step();
        check("t1_idle", 32'(bus.Busy), 32'd0);
        step();

        // 2: match three edges after capture
        drive(1'b1, 16'h00FF, 16'h1234);
        step();
        bus.Write = 1'b0;
        check("t2_busy_e0", 32'(bus.Busy), 32'd1);
        step();
        check("t2_busy_e1", 32'(bus.Busy), 32'd1);
        step();
        check("t2_busy_e2", 32'(bus.Busy), 32'd1);
        bus.O = 16'h00FF;
        push(EV_PASS, 4'd3, '0, '0, 8'd0);
        step();
        check("t2_idle", 32'(bus.Busy), 32'd0);
        step();

        // 3: timeout at MAX_LAT
        do_reset();
        drive(1'b1, 16'hBEEF, 16'h0000);
        step();
        bus.Write = 1'b0;
        push(EV_FAIL, '0, 16'hBEEF, 16'h0000, 8'd1);
        repeat (MAX_LAT) step();
        check("t3_idle", 32'(bus.Busy), 32'd0);
        check("t3_err",  32'(bus.ErrCount), 32'd1);
        step();

        // 4: overrun then pass against the second capture
        do_reset();
        drive(1'b1, 16'h0001, 16'h0000);
        step();
        bus.I = 16'h0002;
        push(EV_OVR, '0, '0, '0, 8'd1);
        step();
        check("t4_busy", 32'(bus.Busy), 32'd1);
        drive(1'b0, 16'h0000, 16'h0002);
        push(EV_PASS, 4'd1, '0, '0, 8'd1);
        step();
        check("t4_err", 32'(bus.ErrCount), 32'd1);
        step();

        // 5: saturate the error counter
        do_reset();
        for (int k = 1; k <= 257; k++) begin
            drive(1'b1, 16'(16'h0100 + k), 16'h0000);
            step();
            bus.Write = 1'b0;
            push(EV_FAIL, '0, 16'(16'h0100 + k), 16'h0000, (k > 255) ? 8'hFF : 8'(k));
            repeat (MAX_LAT) step();
        end
        check("t5_err_sat", 32'(bus.ErrCount), 32'hFF);

        // 6: reset in the middle of a pending check
        drive(1'b1, 16'h00AA, 16'h0000);
        step();
        bus.Write = 1'b0;
        step();
        bus.O = 16'h00AA;
        push(EV_PASS, 4'd2, '0, '0, 8'hFF);
        step();
        step();
        check("t6_lat_pre", 32'(bus.Latency), 32'd2);
        drive(1'b1, 16'h5555, 16'h0000);
        step();
        bus.Write = 1'b0;
        step();
        check("t6_busy_pre", 32'(bus.Busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_busy_rst", 32'(bus.Busy),     32'd0);
        check("t6_err_rst",  32'(bus.ErrCount), 32'd0);
        check("t6_lat_rst",  32'(bus.Latency),  32'd0);
        check("t6_pass_rst", 32'(bus.Pass),     32'd0);
        check("t6_fail_rst", 32'(bus.Fail),     32'd0);
        step();
        step();
        rst_n = 1'b1;
        bus.O = 16'h5555;
        repeat (6) step();
        check("t6_idle_after", 32'(bus.Busy), 32'd0);
        drive(1'b1, 16'h7777, 16'h5555);
        step();
        drive(1'b0, 16'h0000, 16'h7777);
        push(EV_PASS, 4'd1, '0, '0, 8'd0);
        step();
        step();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
